// File: rtl/decode_issue_if.sv
// Decode/issue stage bus: fetch handshake, flush/stall controls, writeback
// port and the registered operand bundle handed to the execute stage.
interface decode_issue_if;
  logic        fetch_valid;
  logic [31:0] fetch_instr;
  logic [31:0] fetch_pc;
  logic        fetch_ready;
  logic        redirect;
  logic        uart_state;
  logic [31:0] ew_d;
  logic [1:0]  ew_rw;
  logic [4:0]  ew_rd;
  logic [31:0] pc;
  logic [5:0]  instr;
  logic [1:0]  op_type;
  logic [31:0] de_s;
  logic [5:0]  de_rs;
  logic [31:0] de_t;
  logic [5:0]  de_rt;
  logic [31:0] imm;
  logic        branch;
  logic        jump;
  logic        is_jr;
  logic        start;

  modport master (
    output fetch_valid, fetch_instr, fetch_pc, redirect, uart_state,
           ew_d, ew_rw, ew_rd,
    input  fetch_ready, pc, instr, op_type, de_s, de_rs, de_t, de_rt,
           imm, branch, jump, is_jr, start
  );

  modport slave (
    input  fetch_valid, fetch_instr, fetch_pc, redirect, uart_state,
           ew_d, ew_rw, ew_rd,
    output fetch_ready, pc, instr, op_type, de_s, de_rs, de_t, de_rt,
           imm, branch, jump, is_jr, start
  );
endinterface

// File: rtl/decode_issue.sv
// Decode/issue stage: integer and float register files with write-through,
// instruction decode, and an issue FSM handling downstream stalls, load bubbles and flushes.
module decode_issue #(
  parameter int unsigned BUBBLE_LW = 1
) (
  input logic           clk,
  input logic           rst,
  decode_issue_if.slave bus
);
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_BLEZ = 6'h06;
  localparam logic [5:0] OP_BGTZ = 6'h07;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_XORI = 6'h0E;
  localparam logic [5:0] OP_FPU  = 6'h11;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_LW_S = 6'h31;
  localparam logic [5:0] FN_JR   = 6'h08;

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD, BUBBLE} state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [5:0]  instr;
    logic [1:0]  op_type;
    logic [31:0] de_s;
    logic [5:0]  de_rs;
    logic [31:0] de_t;
    logic [5:0]  de_rt;
    logic [31:0] imm;
    logic        branch;
    logic        jump;
    logic        is_jr;
    logic        start;
  } issue_t;

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        load_q, load_d;
  issue_t      out_q, out_d;
  issue_t      dec;
  logic        dec_is_load;
  logic        accept;
  logic [31:0] ireg_q [32];
  logic [31:0] ireg_d [32];
  logic [31:0] freg_q [32];
  logic [31:0] freg_d [32];

  // Integer r0 is hardwired to zero; a write landing this cycle is forwarded.
  function automatic logic [31:0] read_rf(
    input logic        use_f,
    input logic [4:0]  idx,
    input logic [1:0]  rw,
    input logic [4:0]  rd,
    input logic [31:0] d,
    input logic [31:0] ival,
    input logic [31:0] fval
  );
    if (use_f)
      return (rw == 2'b10 && rd == idx) ? d : fval;
    else if (idx == 5'd0)
      return '0;
    else
      return (rw == 2'b01 && rd == idx) ? d : ival;
  endfunction

  always_comb begin
    ireg_d = ireg_q;
    freg_d = freg_q;
    if (bus.ew_rw == 2'b01 && bus.ew_rd != 5'd0) ireg_d[bus.ew_rd] = bus.ew_d;
    if (bus.ew_rw == 2'b10)                      freg_d[bus.ew_rd] = bus.ew_d;
  end

  always_comb begin
    logic [5:0] op;
    logic [5:0] funct;
    logic       is_r;
    logic       is_f;
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    op          = bus.fetch_instr[31:26];
    funct       = bus.fetch_instr[5:0];
    is_r        = (op == 6'h00);
    is_f        = (op == OP_FPU);
    dec         = '0;
    dec.pc      = bus.fetch_pc;
    dec.op_type = is_r ? 2'b01 : (is_f ? 2'b10 : 2'b00);
    dec.instr   = (is_r || is_f) ? funct : op;
    dec.de_rs   = {is_f, bus.fetch_instr[25:21]};
    dec.de_rt   = {is_f, bus.fetch_instr[20:16]};
    dec.de_s    = read_rf(is_f, bus.fetch_instr[25:21], bus.ew_rw, bus.ew_rd, bus.ew_d,
                          ireg_q[bus.fetch_instr[25:21]], freg_q[bus.fetch_instr[25:21]]);
    dec.de_t    = read_rf(is_f, bus.fetch_instr[20:16], bus.ew_rw, bus.ew_rd, bus.ew_d,
                          ireg_q[bus.fetch_instr[20:16]], freg_q[bus.fetch_instr[20:16]]);
    if (is_r || op inside {OP_ANDI, OP_ORI, OP_XORI})
      dec.imm = {16'h0000, bus.fetch_instr[15:0]};
    else if (op inside {OP_J, OP_JAL})
      dec.imm = {6'h00, bus.fetch_instr[25:0]};
    else
      dec.imm = {{16{bus.fetch_instr[15]}}, bus.fetch_instr[15:0]};
    dec.branch  = op inside {OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ};
    dec.jump    = op inside {OP_J, OP_JAL};
    dec.is_jr   = is_r && (funct == FN_JR);
    dec.start   = 1'b1;
    dec_is_load = op inside {OP_LW, OP_LW_S};
  end

  // The issue cycle of a load already counts as the first bubble cycle.
  assign bus.fetch_ready = !rst && !bus.uart_state && !bus.redirect && (state_q != BUBBLE)
                        && !(state_q == ISSUE && load_q && (BUBBLE_LW > 0));
  assign accept = bus.fetch_valid && bus.fetch_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    load_d      = load_q;
    out_d       = out_q;
    out_d.start = 1'b0;
    if (bus.redirect) begin
      state_d      = IDLE;
      cnt_d        = '0;
      load_d       = 1'b0;
      out_d.branch = 1'b0;
      out_d.jump   = 1'b0;
      out_d.is_jr  = 1'b0;
    end else if (accept) begin
      out_d   = dec;
      state_d = ISSUE;
      load_d  = dec_is_load;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ISSUE: begin
          if (bus.uart_state) begin
            state_d = HOLD;
          end else if (load_q && BUBBLE_LW > 1) begin
            state_d = BUBBLE;
            cnt_d   = 2'(BUBBLE_LW - 1);
          end else begin
            state_d = IDLE;
          end
        end
        HOLD:   if (!bus.uart_state) state_d = IDLE;
        BUBBLE: begin
          if (cnt_q <= 2'd1) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - 2'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      load_q  <= 1'b0;
      out_q   <= '0;
      // NOTE: the register files are cleared by reset, so they map to flops rather than RAM.
      for (int i = 0; i < 32; i++) begin
        ireg_q[i] <= '0;
        freg_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      load_q  <= load_d;
      out_q   <= out_d;
      ireg_q  <= ireg_d;
      freg_q  <= freg_d;
    end
  end

  assign bus.pc      = out_q.pc;
  assign bus.instr   = out_q.instr;
  assign bus.op_type = out_q.op_type;
  assign bus.de_s    = out_q.de_s;
  assign bus.de_rs   = out_q.de_rs;
  assign bus.de_t    = out_q.de_t;
  assign bus.de_rt   = out_q.de_rt;
  assign bus.imm     = out_q.imm;
  assign bus.branch  = out_q.branch;
  assign bus.jump    = out_q.jump;
  assign bus.is_jr   = out_q.is_jr;
  assign bus.start   = out_q.start;
endmodule

// File: tb/tb_decode_issue.sv
// Self-checking bench for decode_issue: directed scenarios plus random traffic
// compared cycle by cycle against a behavioural model of the issue rules.
module tb_decode_issue;
  localparam int unsigned BLW = 1;
  localparam logic [5:0] OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04, OP_BNE = 6'h05,
                         OP_BLEZ = 6'h06, OP_BGTZ = 6'h07, OP_ADDI = 6'h08, OP_ANDI = 6'h0C,
                         OP_ORI = 6'h0D, OP_XORI = 6'h0E, OP_FPU = 6'h11, OP_LW = 6'h23,
                         OP_SW = 6'h2B, OP_LW_S = 6'h31, OP_OUT = 6'h3F;

  typedef struct packed {
    logic [31:0] pc;
    logic [5:0]  instr;
    logic [1:0]  op_type;
    logic [31:0] de_s;
    logic [5:0]  de_rs;
    logic [31:0] de_t;
    logic [5:0]  de_rt;
    logic [31:0] imm;
    logic        branch;
    logic        jump;
    logic        is_jr;
    logic        start;
  } out_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  decode_issue_if bus ();
  decode_issue_if bus2 ();

  decode_issue #(.BUBBLE_LW(BLW)) dut  (.clk(clk), .rst(rst), .bus(bus));
  decode_issue #(.BUBBLE_LW(3))   dut2 (.clk(clk), .rst(rst), .bus(bus2));

  int          n_assert = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          stall;
  out_t        exp_o;
  logic [31:0] m_ir [32];
  logic [31:0] m_fr [32];
  logic        last_ready;

  task automatic check(input string tag, input logic [151:0] obs, input logic [151:0] expv);
    n_assert++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic out_t observe();
    return {bus.pc, bus.instr, bus.op_type, bus.de_s, bus.de_rs, bus.de_t, bus.de_rt,
            bus.imm, bus.branch, bus.jump, bus.is_jr, bus.start};
  endfunction

  task automatic model_reset();
    exp_o = '0;
    stall = 0;
    for (int i = 0; i < 32; i++) begin
      m_ir[i] = '0;
      m_fr[i] = '0;
    end
  endtask

  function automatic logic [31:0] ref_read(input bit f, input int idx, input logic [1:0] rw,
                                           input logic [4:0] wrd, input logic [31:0] wd);
    if (f) return (rw == 2'b10 && int'(wrd) == idx) ? wd : m_fr[idx];
    if (idx == 0) return 32'h0;
    return (rw == 2'b01 && int'(wrd) == idx) ? wd : m_ir[idx];
  endfunction

  function automatic out_t ref_decode(input logic [31:0] ins, input logic [31:0] p,
                                      input logic [1:0] rw, input logic [4:0] wrd,
                                      input logic [31:0] wd);
    out_t       o;
    logic [5:0] op;
    bit         f;
    op = ins[31:26];
    f  = (op == OP_FPU);
    o  = '0;
    o.pc = p;
    if (op == 6'h00)  begin o.op_type = 2'b01; o.instr = ins[5:0]; end
    else if (f)       begin o.op_type = 2'b10; o.instr = ins[5:0]; end
    else              begin o.op_type = 2'b00; o.instr = op;       end
    o.de_rs = {f, ins[25:21]};
    o.de_rt = {f, ins[20:16]};
    o.de_s  = ref_read(f, int'(ins[25:21]), rw, wrd, wd);
    o.de_t  = ref_read(f, int'(ins[20:16]), rw, wrd, wd);
    if (op == OP_ANDI || op == OP_ORI || op == OP_XORI || op == 6'h00) o.imm = {16'h0, ins[15:0]};
    else if (op == OP_J || op == OP_JAL) o.imm = {6'h0, ins[25:0]};
    else o.imm = {{16{ins[15]}}, ins[15:0]};
    o.branch = (op == OP_BEQ || op == OP_BNE || op == OP_BLEZ || op == OP_BGTZ);
    o.jump   = (op == OP_J || op == OP_JAL);
    o.is_jr  = (op == 6'h00 && ins[5:0] == 6'h08);
    o.start  = 1'b1;
    return o;
  endfunction

  // One clock of the main DUT: drive, check readiness, advance the model, check outputs.
  task automatic step(input logic fv, input logic [31:0] ins, input logic [31:0] p,
                      input logic rd_ = 1'b0, input logic ua = 1'b0,
                      input logic [1:0] rw = 2'b00, input logic [4:0] wrd = 5'd0,
                      input logic [31:0] wd = 32'h0);
    logic ready;
    bus.fetch_valid = fv;
    bus.fetch_instr = ins;
    bus.fetch_pc    = p;
    bus.redirect    = rd_;
    bus.uart_state  = ua;
    bus.ew_rw       = rw;
    bus.ew_rd       = wrd;
    bus.ew_d        = wd;
    #1;
    ready      = !ua && !rd_ && (stall == 0);
    last_ready = bus.fetch_ready;
    check("fetch_ready", bus.fetch_ready, ready);
    if (rd_) begin
      exp_o.start  = 1'b0;
      exp_o.branch = 1'b0;
      exp_o.jump   = 1'b0;
      exp_o.is_jr  = 1'b0;
      stall        = 0;
    end else if (fv && ready) begin
      exp_o = ref_decode(ins, p, rw, wrd, wd);
      stall = (ins[31:26] == OP_LW || ins[31:26] == OP_LW_S) ? int'(BLW) : 0;
    end else begin
      if (exp_o.start && ua) stall = 0;
      else if (stall > 0)    stall--;
      exp_o.start = 1'b0;
    end
    if (rw == 2'b01 && wrd != 5'd0) m_ir[wrd] = wd;
    if (rw == 2'b10)                m_fr[wrd] = wd;
    @(posedge clk);
    #1;
    cyc++;
    check("outputs", observe(), exp_o);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    out_t        saved;
    int          t0, t1;
    bit          found;
    logic [31:0] add_i, r;
    logic [5:0]  ops [15];

    bus.fetch_valid = 0; bus.fetch_instr = 0; bus.fetch_pc = 0; bus.redirect = 0;
    bus.uart_state = 0; bus.ew_d = 0; bus.ew_rw = 0; bus.ew_rd = 0;
    bus2.fetch_valid = 0; bus2.fetch_instr = 0; bus2.fetch_pc = 0; bus2.redirect = 0;
    bus2.uart_state = 0; bus2.ew_d = 0; bus2.ew_rw = 0; bus2.ew_rd = 0;
    add_i = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20};
    model_reset();

    #1 rst = 1'b1;
    #1;
    check("reset_outputs", observe(), '0);
    check("reset_ready", bus.fetch_ready, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("ready_after_reset", bus.fetch_ready, 1'b1);

    // Write-through of r3 into an ADDI fetched the same cycle.
    step(1, {OP_ADDI, 5'd3, 5'd4, 16'hFFFF}, 32'h100, 0, 0, 2'b01, 5'd3, 32'h12345678);
    check("addi_de_s", bus.de_s, 32'h12345678);
    check("addi_imm", bus.imm, 32'hFFFFFFFF);
    check("addi_op_type", bus.op_type, 2'b00);
    check("addi_start", bus.start, 1'b1);
    step(0, 32'h0, 32'h0);
    check("idle_start", bus.start, 1'b0);
    check("idle_keeps_de_s", bus.de_s, 32'h12345678);

    step(1, {OP_ORI, 5'd0, 5'd1, 16'h8000}, 32'h104);
    check("ori_imm", bus.imm, 32'h00008000);
    step(1, {OP_J, 26'h3FFFFFF}, 32'h108);
    check("j_imm", bus.imm, 32'h03FFFFFF);
    check("j_jump", bus.jump, 1'b1);

    // r0 ignores writes; f0 keeps them.
    step(0, 32'h0, 32'h0, 0, 0, 2'b01, 5'd0, 32'hFFFFFFFF);
    step(0, 32'h0, 32'h0, 0, 0, 2'b10, 5'd0, 32'h3F800000);
    step(1, {6'h00, 5'd0, 5'd0, 5'd7, 5'd0, 6'h20}, 32'h10C);
    check("r0_reads_zero", bus.de_s, 32'h0);
    step(1, {OP_FPU, 5'd0, 5'd0, 5'd2, 5'd0, 6'h00}, 32'h110);
    check("f0_reads_value", bus.de_s, 32'h3F800000);
    check("f0_de_rs", bus.de_rs, 6'h20);
    check("fpu_op_type", bus.op_type, 2'b10);

    // Downstream busy for five cycles right after an OUT issues.
    step(1, {OP_OUT, 26'h0}, 32'h300);
    check("out_start", bus.start, 1'b1);
    saved = observe();
    for (int i = 0; i < 5; i++) begin
      step(1, add_i, 32'h304, 0, 1);
      check("hold_ready", last_ready, 1'b0);
      check("hold_frozen", observe() >> 1, saved >> 1);
      check("hold_start", bus.start, 1'b0);
    end
    step(0, 32'h0, 32'h0);

    // Load followed by ADD: one bubble between the two start pulses.
    step(1, {OP_LW, 5'd0, 5'd6, 16'h0010}, 32'h400);
    check("lw_start", bus.start, 1'b1);
    t0 = cyc;
    t1 = 0;
    found = 0;
    for (int i = 0; i < 8 && !found; i++) begin
      step(1, add_i, 32'h404);
      if (bus.start === 1'b1 && bus.pc === 32'h404) begin
        found = 1;
        t1 = cyc;
      end
    end
    check("lw_add_issued", found, 1'b1);
    check("lw_add_gap", t1 - t0, 2);

    // Redirect kills a pending branch and drops the concurrent fetch.
    step(1, {OP_BEQ, 5'd1, 5'd2, 16'h0008}, 32'h500);
    check("beq_branch", bus.branch, 1'b1);
    step(1, add_i, 32'h504, 1);
    check("redirect_start", bus.start, 1'b0);
    check("redirect_branch", bus.branch, 1'b0);
    check("redirect_drop_pc", bus.pc, 32'h500);

    // Redirect together with uart_state keeps the data frozen.
    step(1, {OP_OUT, 26'h155}, 32'h600);
    saved = observe();
    step(1, add_i, 32'h604, 1, 1);
    check("redirect_uart_frozen", observe() >> 4, saved >> 4);
    step(0, 32'h0, 32'h0);

    // Reset in the middle of a HOLD.
    step(1, {OP_OUT, 26'h0}, 32'h700);
    step(0, 32'h0, 32'h0, 0, 1);
    bus.uart_state = 1'b0;
    rst = 1'b1;
    #1;
    check("midhold_reset_outputs", observe(), '0);
    check("midhold_reset_ready", bus.fetch_ready, 1'b0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(0, 32'h0, 32'h0);
    check("midhold_no_start", bus.start, 1'b0);

    // Random traffic against the model.
    ops = '{6'h00, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_BLEZ, OP_ADDI, OP_ANDI, OP_ORI,
            OP_XORI, OP_FPU, OP_LW, OP_SW, OP_LW_S, OP_OUT};
    for (int i = 0; i < 600; i++) begin
      logic [31:0] ins;
      r   = $urandom();
      ins = {ops[$urandom_range(0, 14)], 2'b00, r[2:0], 2'b00, r[5:3], r[15:0]};
      if (ins[31:26] == 6'h00 && r[20]) ins[5:0] = 6'h08;
      step(($urandom_range(0, 3) != 0), ins, $urandom(),
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0),
           2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)), $urandom());
    end

    // BUBBLE_LW = 3 instance: redirect inside BUBBLE with a fetch waiting.
    bus2.fetch_instr = {OP_LW, 5'd1, 5'd2, 16'h0004};
    bus2.fetch_pc    = 32'h200;
    bus2.fetch_valid = 1'b1;
    #1;
    check("b3_ready_idle", bus2.fetch_ready, 1'b1);
    @(posedge clk); #1;
    check("b3_lw_start", bus2.start, 1'b1);
    bus2.fetch_instr = add_i;
    bus2.fetch_pc    = 32'h204;
    #1;
    check("b3_issue_ready", bus2.fetch_ready, 1'b0);
    @(posedge clk); #1;
    check("b3_bubble_start", bus2.start, 1'b0);
    check("b3_bubble_ready", bus2.fetch_ready, 1'b0);
    bus2.redirect = 1'b1;
    #1;
    check("b3_redirect_ready", bus2.fetch_ready, 1'b0);
    @(posedge clk); #1;
    bus2.redirect    = 1'b0;
    bus2.fetch_valid = 1'b0;
    check("b3_no_start", bus2.start, 1'b0);
    check("b3_fetch_dropped", bus2.pc, 32'h200);
    #1;
    check("b3_idle_ready", bus2.fetch_ready, 1'b1);
    @(posedge clk); #1;
    check("b3_still_no_start", bus2.start, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
